// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the memory arbiter.
//   ramstate_t : RAM status reported back to the arbiter
//   owner_t    : which requester currently holds the RAM port
//   word_t     : native CPU data word
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } owner_t;

  localparam int WORD_W   = 32;
  localparam int STARVE_W = 4;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the RAM.
//   requester side : iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload
//   RAM side       : ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate
//   debug          : owner
// slave  = arbiter view, master = environment (pipeline + RAM) view.
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  ramstate_t         ramstate;

  owner_t            owner;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, owner
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, owner
  );

endinterface

// File: rtl/starve_counter.sv
// Saturating count of consecutive data completions seen while a fetch waits.
//   CLK, nRST : clock, async active-low reset
//   inc       : count one data completion (ignored once saturated)
//   clr       : clear; wins over inc
//   full      : count has reached STARVE_MAX
module starve_counter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic full
);

  logic [STARVE_W-1:0] cnt;

  assign full = (cnt == STARVE_W'(STARVE_MAX));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !full) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data memory.
// Data wins by default; after STARVE_MAX data completions with a fetch
// pending, the next grant is forced to the fetch. A granted transaction
// is latched and replayed to the RAM until it reports ACCESS.
//   CLK, nRST : clock, async active-low reset
//   bus       : requester, RAM and debug signals (slave modport)
//
// state | meaning
// NONE  | port free; live winner drives the RAM this cycle
// INST  | fetch in flight, RAM driven from txn_* latches
// DATA  | data access in flight, RAM driven from txn_* latches
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  owner_t            owner_q, owner_n, cur_owner;
  logic [ADDR_W-1:0] txn_addr;
  logic [DATA_W-1:0] txn_store;
  logic              txn_wen;

  logic              d_req, grant_inst, grant_data, grant;
  logic              ram_ren, ram_wen, done, i_done, d_done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_store;
  logic              starve_full;

  // Arbitration only happens while the port is free. Gating with nRST keeps
  // the RAM quiet during reset even though requests may still be present.
  always_comb begin
    d_req      = bus.dREN | bus.dWEN;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (nRST && (owner_q == NONE)) begin
      grant_inst = bus.iREN && (!d_req || starve_full);
      grant_data = d_req && !grant_inst;
    end
    grant = grant_inst | grant_data;
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner_q <= NONE;
    end else begin
      owner_q <= owner_n;
    end
  end

  // Next-state logic; a grant that completes in its own cycle never leaves NONE
  always_comb begin
    owner_n = owner_q;
    unique case (owner_q)
      NONE: begin
        if (grant && !done) begin
          owner_n = cur_owner;
        end
      end
      INST, DATA: begin
        if (done) begin
          owner_n = NONE;
        end
      end
      default: owner_n = NONE;
    endcase
  end

  // Output logic: RAM mux and requester handshakes
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    cur_owner = owner_q;
    if (owner_q == INST || owner_q == DATA) begin
      ram_ren   = !txn_wen;
      ram_wen   = txn_wen;
      ram_addr  = txn_addr;
      ram_store = txn_store;
    end else if (grant_data) begin
      cur_owner = DATA;
      ram_ren   = !bus.dWEN;
      ram_wen   = bus.dWEN;
      ram_addr  = bus.daddr;
      ram_store = bus.dWEN ? bus.dstore : '0;
    end else if (grant_inst) begin
      cur_owner = INST;
      ram_ren   = 1'b1;
      ram_addr  = bus.iaddr;
    end

    done   = (ram_ren | ram_wen) && (bus.ramstate == ACCESS);
    i_done = done && (cur_owner == INST);
    d_done = done && (cur_owner == DATA);
  end

  // A dropped request still completes, but its result is not handed back
  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iwait    = bus.iREN && !i_done;
  assign bus.dwait    = d_req && !d_done;
  assign bus.iload    = (i_done && bus.iREN) ? bus.ramload : '0;
  assign bus.dload    = (d_done && bus.dREN) ? bus.ramload : '0;
  assign bus.owner    = owner_q;

  // Capture the winning request so later cycles ignore live input changes
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      txn_addr  <= '0;
      txn_store <= '0;
      txn_wen   <= 1'b0;
    end else if (grant) begin
      txn_addr  <= ram_addr;
      txn_store <= ram_store;
      txn_wen   <= ram_wen;
    end
  end

  starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (d_done && bus.iREN),
    .clr  (grant_inst || (d_done && !bus.iREN)),
    .full (starve_full)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-cycle arbitration vectors
// followed by hand-written multi-cycle sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic clk;
  logic nrst;
  int   tests;
  int   fails;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iren;
    logic [31:0] iaddr;
    logic        dren;
    logic        dwen;
    logic [31:0] daddr;
    logic [31:0] dstore;
    ramstate_t   rs;
    logic [31:0] rload;
    logic        e_rren;
    logic        e_rwen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic        e_iwait;
    logic        e_dwait;
    logic [31:0] e_iload;
    logic [31:0] e_dload;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iren, input logic [31:0] iaddr,
                       input logic dren, input logic dwen,
                       input logic [31:0] daddr, input logic [31:0] dstore,
                       input ramstate_t rs, input logic [31:0] rload);
    bus.iREN     = iren;
    bus.iaddr    = iaddr;
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.daddr    = daddr;
    bus.dstore   = dstore;
    bus.ramstate = rs;
    bus.ramload  = rload;
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // iren iaddr dren dwen daddr dstore rs rload | rren rwen addr store iwait dwait iload dload
    vecs[0] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        FREE,   32'h0,
                1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,   32'h0,        ACCESS, 32'h8C220004,
                1'b1, 1'b0, 32'h40,  32'h0,        1'b0, 1'b0, 32'h8C220004, 32'h0};
    vecs[2] = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h80,  32'h0,        ACCESS, 32'h11112222,
                1'b1, 1'b0, 32'h80,  32'h0,        1'b0, 1'b0, 32'h0,        32'h11112222};
    vecs[3] = '{1'b1, 32'h44, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, ACCESS, 32'h5555,
                1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h104, 32'hCAFEF00D, ACCESS, 32'h77,
                1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        32'h77};
    vecs[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0,        ACCESS, 32'h99,
                1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 32'h0,        32'h0};
    vecs[6] = '{1'b1, 32'h48, 1'b1, 1'b0, 32'h84,  32'h0,        ACCESS, 32'h1234,
                1'b1, 1'b0, 32'h84,  32'h0,        1'b1, 1'b0, 32'h0,        32'h1234};

    // Reset state with requests present
    nrst = 1'b0;
    drive(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, ACCESS, 32'hFFFF);
    #2;
    check("rst_ramREN", 64'(bus.ramREN), 64'd0);
    check("rst_ramWEN", 64'(bus.ramWEN), 64'd0);
    check("rst_ramaddr", 64'(bus.ramaddr), 64'd0);
    check("rst_iwait", 64'(bus.iwait), 64'd1);
    check("rst_dwait", 64'(bus.dwait), 64'd1);
    check("rst_iload", 64'(bus.iload), 64'd0);
    check("rst_dload", 64'(bus.dload), 64'd0);
    check("rst_owner", 64'(bus.owner), 64'(NONE));
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    #10 nrst = 1'b1;
    step();

    // Table-driven single-cycle vectors (each completes or idles)
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].iren, vecs[i].iaddr, vecs[i].dren, vecs[i].dwen,
            vecs[i].daddr, vecs[i].dstore, vecs[i].rs, vecs[i].rload);
      #3;
      check($sformatf("v%0d_ramREN", i),   64'(bus.ramREN),   64'(vecs[i].e_rren));
      check($sformatf("v%0d_ramWEN", i),   64'(bus.ramWEN),   64'(vecs[i].e_rwen));
      check($sformatf("v%0d_ramaddr", i),  64'(bus.ramaddr),  64'(vecs[i].e_addr));
      check($sformatf("v%0d_ramstore", i), 64'(bus.ramstore), 64'(vecs[i].e_store));
      check($sformatf("v%0d_iwait", i),    64'(bus.iwait),    64'(vecs[i].e_iwait));
      check($sformatf("v%0d_dwait", i),    64'(bus.dwait),    64'(vecs[i].e_dwait));
      check($sformatf("v%0d_iload", i),    64'(bus.iload),    64'(vecs[i].e_iload));
      check($sformatf("v%0d_dload", i),    64'(bus.dload),    64'(vecs[i].e_dload));
      step();
      check($sformatf("v%0d_owner", i),    64'(bus.owner),    64'(NONE));
    end

    // Data over fetch, 2 BUSY cycles then ACCESS, then the fetch is granted
    drive(1'b1, 32'h60, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, BUSY, 32'h0);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.ramstate = ACCESS;
      #3;
      check($sformatf("dof_c%0d_ramWEN", c),  64'(bus.ramWEN),  64'd1);
      check($sformatf("dof_c%0d_ramaddr", c), 64'(bus.ramaddr), 64'h100);
      check($sformatf("dof_c%0d_dwait", c),   64'(bus.dwait),   (c == 2) ? 64'd0 : 64'd1);
      check($sformatf("dof_c%0d_iwait", c),   64'(bus.iwait),   64'd1);
      step();
      check($sformatf("dof_c%0d_owner", c),   64'(bus.owner),   (c == 2) ? 64'(NONE) : 64'(DATA));
    end
    drive(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'hAAAA);
    #3;
    check("dof_c3_ramREN", 64'(bus.ramREN), 64'd1);
    check("dof_c3_ramaddr", 64'(bus.ramaddr), 64'h60);
    check("dof_c3_iload", 64'(bus.iload), 64'hAAAA);
    step();

    // Starvation: 4 data completions, 5th grant forced to INST, then data again
    drive(1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0, ACCESS, 32'h5A5A);
    for (int k = 0; k < 6; k++) begin
      #3;
      check($sformatf("stv_k%0d_ramaddr", k), 64'(bus.ramaddr), (k == 4) ? 64'h300 : 64'h200);
      check($sformatf("stv_k%0d_iwait", k),   64'(bus.iwait),   (k == 4) ? 64'd0 : 64'd1);
      check($sformatf("stv_k%0d_dwait", k),   64'(bus.dwait),   (k == 4) ? 64'd1 : 64'd0);
      step();
      if (k == 3) check("stv_cnt_full", 64'(dut.u_starve.cnt), 64'd4);
      if (k == 4) check("stv_cnt_clr", 64'(dut.u_starve.cnt), 64'd0);
    end

    // Latch hold: address change and request drop are ignored until ACCESS
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, BUSY, 32'hBBBB);
    #3;
    check("lh_c0_ramaddr", 64'(bus.ramaddr), 64'h200);
    check("lh_c0_dwait", 64'(bus.dwait), 64'd1);
    step();
    bus.daddr = 32'h300;
    bus.dREN  = 1'b0;
    #3;
    check("lh_c1_ramREN", 64'(bus.ramREN), 64'd1);
    check("lh_c1_ramaddr", 64'(bus.ramaddr), 64'h200);
    check("lh_c1_dwait", 64'(bus.dwait), 64'd0);
    step();
    bus.ramstate = ACCESS;
    #3;
    check("lh_c2_ramaddr", 64'(bus.ramaddr), 64'h200);
    check("lh_c2_dload", 64'(bus.dload), 64'd0);
    step();
    check("lh_owner_free", 64'(bus.owner), 64'(NONE));
    #1;
    check("lh_idle_ramREN", 64'(bus.ramREN), 64'd0);

    // ERROR, ERROR, ACCESS on a fetch
    drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, ERROR, 32'h0BADF00D);
    for (int c = 0; c < 3; c++) begin
      if (c == 2) bus.ramstate = ACCESS;
      #3;
      check($sformatf("err_c%0d_ramREN", c), 64'(bus.ramREN), 64'd1);
      check($sformatf("err_c%0d_iwait", c),  64'(bus.iwait),  (c == 2) ? 64'd0 : 64'd1);
      check($sformatf("err_c%0d_iload", c),  64'(bus.iload),  (c == 2) ? 64'h0BADF00D : 64'd0);
      step();
      check($sformatf("err_c%0d_owner", c),  64'(bus.owner),  (c == 2) ? 64'(NONE) : 64'(INST));
    end
    bus.iREN = 1'b0;

    // Reset pulsed during a BUSY write, then the same request re-arbitrates
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 32'h12345678, BUSY, 32'h0);
    #3;
    check("rmo_c0_ramWEN", 64'(bus.ramWEN), 64'd1);
    step();
    check("rmo_owner_data", 64'(bus.owner), 64'(DATA));
    #1 nrst = 1'b0;
    #1;
    check("rmo_rst_ramWEN", 64'(bus.ramWEN), 64'd0);
    check("rmo_rst_owner", 64'(bus.owner), 64'(NONE));
    check("rmo_rst_dwait", 64'(bus.dwait), 64'd1);
    #1 nrst = 1'b1;
    #1;
    check("rmo_rel_ramWEN", 64'(bus.ramWEN), 64'd1);
    check("rmo_rel_ramaddr", 64'(bus.ramaddr), 64'h400);
    check("rmo_rel_ramstore", 64'(bus.ramstore), 64'h12345678);
    step();
    bus.ramstate = ACCESS;
    #3;
    check("rmo_done_dwait", 64'(bus.dwait), 64'd0);
    step();
    check("rmo_done_owner", 64'(bus.owner), 64'(NONE));
    bus.dWEN = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
